// File: rtl/sd_bd_store_pkg.sv
// Shared definitions for the SD buffer-descriptor store: default widths and
// the one-hot read FSM encoding.
package sd_bd_store_pkg;

  localparam int MEM_WIDTH_DEF = 32;
  localparam int BD_DEPTH_DEF  = 8;
  localparam int BD_SIZE_DEF   = 2 * BD_DEPTH_DEF;

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    READ     = 3'b010,
    WAIT_CMP = 3'b100
  } rd_state_e;

endpackage

// File: rtl/sd_bd_ram.sv
// Simple dual-port descriptor RAM: one write port, one registered read port.
// Only the read data register is reset; the array itself is not.
module sd_bd_ram #(
  parameter int WIDTH = 32,
  parameter int ADR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ADR_W-1:0] wadr,
  input  logic [WIDTH-1:0] wdat,
  input  logic             re,
  input  logic [ADR_W-1:0] radr,
  output logic [WIDTH-1:0] rdat
);

  logic [WIDTH-1:0] r_mem [2**ADR_W];
  logic [WIDTH-1:0] r_rdat;

  always_ff @(posedge clk) begin
    if (we) r_mem[wadr] <= wdat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_rdat <= '0;
    else if (re) r_rdat <= r_mem[radr];
  end

  assign rdat = r_rdat;

endmodule

// File: rtl/sd_bd_store.sv
// Buffer-descriptor store: host writes two-word descriptors into a ring, the
// data master reads them back word by word and releases each slot on a_cmp.
module sd_bd_store
  import sd_bd_store_pkg::*;
#(
  parameter int MEM_WIDTH = MEM_WIDTH_DEF,
  parameter int BD_DEPTH  = BD_DEPTH_DEF,
  parameter int BD_WIDTH  = $clog2(BD_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_h,
  input  logic [MEM_WIDTH-1:0] dat_h,
  output logic                 wr_ovf,
  input  logic                 re_s,
  output logic                 ack_o_s,
  output logic [MEM_WIDTH-1:0] dat_out_s,
  input  logic                 a_cmp,
  output logic [BD_WIDTH-1:0]  free_bd
);

  localparam int PTR_W = $clog2(BD_DEPTH);
  localparam int ADR_W = PTR_W + 1;

  logic [PTR_W-1:0]    r_wr_ptr;
  logic                r_wr_word;
  logic                r_wr_ovf;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [1:0]          r_rd_word;
  logic                r_a_cmp_q;
  logic                r_ack;
  logic [BD_WIDTH-1:0] r_free_bd;
  rd_state_e           r_state;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic             w_commit;
  logic             w_rd_en;
  logic             w_release;
  logic [ADR_W-1:0] w_wr_adr;
  logic [ADR_W-1:0] w_rd_adr;

  assign w_full    = (r_free_bd == '0);
  assign w_empty   = (r_free_bd == BD_WIDTH'(BD_DEPTH));
  // Only the first word of a descriptor is gated on space; the second word
  // always completes a descriptor whose slot was already reserved.
  assign w_wr_en   = we_h & (r_wr_word | ~w_full);
  assign w_commit  = we_h & r_wr_word;
  assign w_wr_adr  = {r_wr_ptr, r_wr_word};
  assign w_rd_en   = (r_state == READ) & re_s & ~r_rd_word[1];
  assign w_rd_adr  = {r_rd_ptr, r_rd_word[0]};
  assign w_release = (r_state == WAIT_CMP) & a_cmp & ~r_a_cmp_q;

  sd_bd_ram #(
    .WIDTH (MEM_WIDTH),
    .ADR_W (ADR_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (w_wr_en),
    .wadr (w_wr_adr),
    .wdat (dat_h),
    .re   (w_rd_en),
    .radr (w_rd_adr),
    .rdat (dat_out_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_wr_word <= 1'b0;
      r_wr_ovf  <= 1'b0;
    end else begin
      r_wr_ovf <= we_h & ~r_wr_word & w_full;
      if (w_wr_en) begin
        r_wr_word <= ~r_wr_word;
        if (r_wr_word) r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_free_bd <= BD_WIDTH'(BD_DEPTH);
    end else if (w_commit && !w_release && !w_full) begin
      r_free_bd <= r_free_bd - 1'b1;
    end else if (w_release && !w_commit && !w_empty) begin
      r_free_bd <= r_free_bd + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rd_ptr  <= '0;
      r_rd_word <= '0;
      r_a_cmp_q <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_a_cmp_q <= a_cmp;
      r_ack     <= w_rd_en;
      case (r_state)
        IDLE: begin
          if (re_s && !w_empty) r_state <= READ;
        end
        READ: begin
          if (w_rd_en) begin
            r_rd_word <= r_rd_word + 1'b1;
            if (r_rd_word[0]) r_state <= WAIT_CMP;
          end
        end
        WAIT_CMP: begin
          if (w_release) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_rd_word <= '0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_ovf  = r_wr_ovf;
  assign ack_o_s = r_ack;
  assign free_bd = r_free_bd;

endmodule

// File: tb/tb_sd_bd_store.sv
// Directed bench for sd_bd_store: a per-cycle vector table for the basic
// write/read/release path, plus hand-written multi-cycle corner sequences.
module tb_sd_bd_store;

  logic        clk;
  logic        rst;
  logic        we_h;
  logic [31:0] dat_h;
  logic        wr_ovf;
  logic        re_s;
  logic        ack_o_s;
  logic [31:0] dat_out_s;
  logic        a_cmp;
  logic [3:0]  free_bd;

  int total = 0;
  int bad   = 0;

  sd_bd_store #(
    .MEM_WIDTH (32),
    .BD_DEPTH  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we_h      (we_h),
    .dat_h     (dat_h),
    .wr_ovf    (wr_ovf),
    .re_s      (re_s),
    .ack_o_s   (ack_o_s),
    .dat_out_s (dat_out_s),
    .a_cmp     (a_cmp),
    .free_bd   (free_bd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] dat;
    logic        re;
    logic        acmp;
    logic        exp_ack;
    logic [31:0] exp_dat;
    logic        exp_ovf;
    logic [3:0]  exp_free;
  } vec_t;

  vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    we_h  = 1'b0;
    dat_h = '0;
    re_s  = 1'b0;
    a_cmp = 1'b0;
    rst   = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic write_desc(input logic [31:0] d0, input logic [31:0] d1);
    we_h  = 1'b1;
    dat_h = d0;
    step();
    dat_h = d1;
    step();
    we_h = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (!ack_o_s && n < 10) begin
      step();
      n++;
    end
    if (!ack_o_s) chk({name, "_ack_timeout"}, {31'b0, ack_o_s}, 32'd1);
  endtask

  task automatic read_desc(input string name, input logic [31:0] d0, input logic [31:0] d1);
    re_s = 1'b1;
    step();
    wait_ack(name);
    chk({name, "_w0"}, dat_out_s, d0);
    step();
    chk({name, "_ack1"}, {31'b0, ack_o_s}, 32'd1);
    chk({name, "_w1"}, dat_out_s, d1);
    step();
    chk({name, "_ack_end"}, {31'b0, ack_o_s}, 32'd0);
    re_s = 1'b0;
  endtask

  task automatic complete(input string name, input logic [3:0] exp_free);
    a_cmp = 1'b1;
    step();
    chk({name, "_free_rel"}, {28'b0, free_bd}, {28'b0, exp_free});
    step();
    a_cmp = 1'b0;
    step();
    chk({name, "_free_hold"}, {28'b0, free_bd}, {28'b0, exp_free});
  endtask

  initial begin
    // basic path from reset: inputs before edge k, outputs checked after it
    vecs[0]  = '{1'b1, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 4'd8};
    vecs[1]  = '{1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 4'd7};
    vecs[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 4'd7};
    vecs[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1000_0000, 1'b0, 4'd7};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 4'd7};
    vecs[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 4'd7};
    vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 4'd8};
    vecs[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 4'd8};
    vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 4'd8};
    vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 4'd8};
    vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 4'd8};

    do_reset();
    chk("rst_free", {28'b0, free_bd}, 32'd8);
    chk("rst_ack", {31'b0, ack_o_s}, 32'd0);
    chk("rst_ovf", {31'b0, wr_ovf}, 32'd0);
    chk("rst_dat", dat_out_s, 32'd0);

    re_s = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("empty_no_ack", {31'b0, ack_o_s}, 32'd0);
    end
    re_s = 1'b0;

    do_reset();
    for (int k = 0; k < 11; k++) begin
      we_h  = vecs[k].we;
      dat_h = vecs[k].dat;
      re_s  = vecs[k].re;
      a_cmp = vecs[k].acmp;
      step();
      chk($sformatf("vec%0d_ack", k), {31'b0, ack_o_s}, {31'b0, vecs[k].exp_ack});
      chk($sformatf("vec%0d_ovf", k), {31'b0, wr_ovf}, {31'b0, vecs[k].exp_ovf});
      chk($sformatf("vec%0d_free", k), {28'b0, free_bd}, {28'b0, vecs[k].exp_free});
      if (vecs[k].exp_ack) chk($sformatf("vec%0d_dat", k), dat_out_s, vecs[k].exp_dat);
    end
    we_h  = 1'b0;
    a_cmp = 1'b0;

    // full ring and overflow
    do_reset();
    for (int i = 0; i < 8; i++) write_desc(32'hA0 + i, 32'hB0 + i);
    chk("full_free", {28'b0, free_bd}, 32'd0);
    we_h  = 1'b1;
    dat_h = 32'hDEAD_BEEF;
    step();
    we_h = 1'b0;
    chk("ovf_pulse", {31'b0, wr_ovf}, 32'd1);
    chk("ovf_free", {28'b0, free_bd}, 32'd0);
    step();
    chk("ovf_clear", {31'b0, wr_ovf}, 32'd0);
    read_desc("full_d0", 32'hA0, 32'hB0);
    complete("full_d0", 4'd1);
    read_desc("full_d1", 32'hA1, 32'hB1);
    complete("full_d1", 4'd2);

    // ring wrap
    do_reset();
    for (int i = 0; i < 11; i++) begin
      write_desc(i, i + 32'h100);
      step();
      chk($sformatf("wrap%0d_free", i), {28'b0, free_bd}, 32'd7);
      read_desc($sformatf("wrap%0d", i), i, i + 32'h100);
      complete($sformatf("wrap%0d", i), 4'd8);
    end

    // commit and release in the same cycle
    do_reset();
    for (int i = 0; i < 3; i++) write_desc(32'hC0 + i, 32'hD0 + i);
    chk("cr_free_pre", {28'b0, free_bd}, 32'd5);
    read_desc("cr_d0", 32'hC0, 32'hD0);
    we_h  = 1'b1;
    dat_h = 32'hC3;
    step();
    dat_h = 32'hD3;
    a_cmp = 1'b1;
    step();
    we_h = 1'b0;
    chk("cr_free_same", {28'b0, free_bd}, 32'd5);
    step();
    a_cmp = 1'b0;
    chk("cr_free_held", {28'b0, free_bd}, 32'd5);
    read_desc("cr_d1", 32'hC1, 32'hD1);
    complete("cr_d1", 4'd6);
    read_desc("cr_d2", 32'hC2, 32'hD2);
    complete("cr_d2", 4'd7);
    read_desc("cr_d3", 32'hC3, 32'hD3);
    complete("cr_d3", 4'd8);

    // re_s dropped between words
    do_reset();
    write_desc(32'hE0, 32'hF0);
    re_s = 1'b1;
    step();
    wait_ack("pause");
    chk("pause_w0", dat_out_s, 32'hE0);
    re_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause_no_ack", {31'b0, ack_o_s}, 32'd0);
    end
    re_s = 1'b1;
    step();
    chk("resume_ack", {31'b0, ack_o_s}, 32'd1);
    chk("resume_w1", dat_out_s, 32'hF0);
    step();
    chk("resume_ack_end", {31'b0, ack_o_s}, 32'd0);
    re_s = 1'b0;
    complete("pause", 4'd8);

    // reset asserted between the two words of a read
    write_desc(32'hE1, 32'hF1);
    re_s = 1'b1;
    step();
    wait_ack("mid_rst");
    re_s = 1'b0;
    step();
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_free", {28'b0, free_bd}, 32'd8);
    chk("mid_rst_ack", {31'b0, ack_o_s}, 32'd0);
    chk("mid_rst_dat", dat_out_s, 32'd0);
    step();
    rst  = 1'b0;
    re_s = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_no_ack", {31'b0, ack_o_s}, 32'd0);
    end
    re_s = 1'b0;
    chk("post_rst_free", {28'b0, free_bd}, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
